// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROR/ROL on WIDTH-bit operands.
// The log2(WIDTH) shift levels are spread over PIPE_STAGES register stages,
// with a single global advance so the pipe has fixed latency and no bubble
// compression. Carry is carried through the stages with the partial result.
module barrel_shifter_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned AMT_W       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

  // Levels handled per stage; trailing stages may get fewer (or none).
  localparam int unsigned LPS = (AMT_W + PIPE_STAGES - 1) / PIPE_STAGES;

  // Applies the mux levels owned by one stage. Levels are processed in
  // ascending order, so the carry left by the last active level is the last
  // bit shifted out by the whole amount (or the wrapped bit for rotates).
  function automatic logic [WIDTH:0] f_levels(
    input logic [WIDTH-1:0] d,
    input logic             c,
    input logic [2:0]       op,
    input logic [AMT_W-1:0] amt,
    input int unsigned      stage
  );
    logic [WIDTH-1:0] cur;
    logic             cy;
    int unsigned      sh;
    logic [AMT_W-1:0] idx_hi;
    logic [AMT_W-1:0] idx_lo;
    cur = d;
    cy  = c;
    for (int unsigned k = 0; k < AMT_W; k++) begin
      sh     = 32'd1 << k;
      idx_hi = AMT_W'(WIDTH - sh);
      idx_lo = AMT_W'(sh - 1);
      if (k >= stage * LPS && k < (stage + 1) * LPS &&
          ((amt >> k) & AMT_W'(1)) != '0) begin
        case (op)
          OP_SLL: begin cy = cur[idx_hi]; cur = cur << sh; end
          OP_SRL: begin cy = cur[idx_lo]; cur = cur >> sh; end
          OP_SRA: begin cy = cur[idx_lo]; cur = WIDTH'($signed(cur) >>> sh); end
          OP_ROR: begin cur = (cur >> sh) | (cur << (WIDTH - sh)); cy = cur[WIDTH-1]; end
          OP_ROL: begin cur = (cur << sh) | (cur >> (WIDTH - sh)); cy = cur[0]; end
          default: ;
        endcase
      end
    end
    return {cy, cur};
  endfunction

  logic             r_valid [PIPE_STAGES];
  logic [WIDTH-1:0] r_data  [PIPE_STAGES];
  logic             r_carry [PIPE_STAGES];
  logic [2:0]       r_op    [PIPE_STAGES];
  logic [AMT_W-1:0] r_amt   [PIPE_STAGES];
  logic             r_zero;

  logic             w_adv;
  logic [WIDTH-1:0] w_nd [PIPE_STAGES];
  logic             w_nc [PIPE_STAGES];

  assign w_adv     = out_ready || !out_valid;
  assign in_ready  = w_adv;
  assign out_valid = r_valid[PIPE_STAGES-1];
  assign out_data  = r_data[PIPE_STAGES-1];
  assign out_carry = r_carry[PIPE_STAGES-1];
  assign out_zero  = r_zero;

  // Next-state value of every stage: its own levels applied to its predecessor.
  always_comb begin
    for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
      w_nd[s] = '0;
      w_nc[s] = 1'b0;
    end
    {w_nc[0], w_nd[0]} = f_levels(in_data, 1'b0, in_op, in_amt, 0);
    for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
      {w_nc[s], w_nd[s]} = f_levels(r_data[s-1], r_carry[s-1], r_op[s-1], r_amt[s-1], s);
    end
  end

  // Stage registers: all advance together or all hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
        r_valid[s] <= 1'b0;
        r_data[s]  <= '0;
        r_carry[s] <= 1'b0;
        r_op[s]    <= '0;
        r_amt[s]   <= '0;
      end
      r_zero <= 1'b0;
    end else if (w_adv) begin
      r_valid[0] <= in_valid;
      r_data[0]  <= w_nd[0];
      r_carry[0] <= w_nc[0];
      r_op[0]    <= in_op;
      r_amt[0]   <= in_amt;
      for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_data[s]  <= w_nd[s];
        r_carry[s] <= w_nc[s];
        r_op[s]    <= r_op[s-1];
        r_amt[s]   <= r_amt[s-1];
      end
      r_zero <= (w_nd[PIPE_STAGES-1] == '0);
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe: directed table, stall stream,
// mid-flight reset and randomised sweeps on 8/1 and 64/6 configurations.
module tb_barrel_shifter_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // DUT0: WIDTH=32, PIPE_STAGES=2
  logic v0, ir0, ov0, or0, c0, z0;
  logic [31:0] d0, od0;
  logic [4:0]  a0;
  logic [2:0]  op0;
  // DUT1: WIDTH=8, PIPE_STAGES=1
  logic v1, ir1, ov1, or1, c1, z1;
  logic [7:0]  d1, od1;
  logic [2:0]  a1;
  logic [2:0]  op1;
  // DUT2: WIDTH=64, PIPE_STAGES=6
  logic v2, ir2, ov2, or2, c2, z2;
  logic [63:0] d2, od2;
  logic [5:0]  a2;
  logic [2:0]  op2;

  barrel_shifter_pipe #(.WIDTH(32), .PIPE_STAGES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(ir0), .in_data(d0),
    .in_amt(a0), .in_op(op0), .out_valid(ov0), .out_ready(or0),
    .out_data(od0), .out_carry(c0), .out_zero(z0));
  barrel_shifter_pipe #(.WIDTH(8), .PIPE_STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1), .in_data(d1),
    .in_amt(a1), .in_op(op1), .out_valid(ov1), .out_ready(or1),
    .out_data(od1), .out_carry(c1), .out_zero(z1));
  barrel_shifter_pipe #(.WIDTH(64), .PIPE_STAGES(6)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ir2), .in_data(d2),
    .in_amt(a2), .in_op(op2), .out_valid(ov2), .out_ready(or2),
    .out_data(od2), .out_carry(c2), .out_zero(z2));

  typedef struct { logic [63:0] d; logic c; logic z; } exp_t;
  typedef struct {
    logic [2:0]  op;
    logic [63:0] d;
    int          amt;
    logic [63:0] ed;
    logic        ec;
    logic        ez;
  } vec_t;

  exp_t        q [3][$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pop [3] = '{0, 0, 0};
  logic        stall_prev [3] = '{1'b0, 1'b0, 1'b0};
  logic [63:0] prev_d [3];
  logic        prev_c [3];
  logic        prev_z [3];
  logic        sweep_on = 1'b0;
  vec_t        tbl [11];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: shifts on a WIDTH-w operand held in 64 bits.
  function automatic exp_t model(input int w, input logic [63:0] din, input int amt,
                                 input logic [2:0] op);
    exp_t        e;
    logic [63:0] mask;
    logic [63:0] d;
    logic [63:0] r;
    logic        c;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    d = din & mask;
    r = d;
    c = 1'b0;
    case (op)
      3'd0: begin r = (d << amt) & mask; if (amt != 0) c = d[w-amt]; end
      3'd1: begin r = d >> amt; if (amt != 0) c = d[amt-1]; end
      3'd2: begin
        r = d >> amt;
        if (amt != 0) begin
          c = d[amt-1];
          if (d[w-1]) r = r | (mask & ~(mask >> amt));
        end
      end
      3'd3: if (amt != 0) begin r = ((d >> amt) | (d << (w - amt))) & mask; c = r[w-1]; end
      3'd4: if (amt != 0) begin r = ((d << amt) | (d >> (w - amt))) & mask; c = r[0]; end
      default: ;
    endcase
    e.d = r;
    e.c = c;
    e.z = (r == 64'd0);
    return e;
  endfunction

  function automatic int wid(input int id);
    return (id == 0) ? 32 : (id == 1) ? 8 : 64;
  endfunction

  function automatic logic rdy(input int id);
    return (id == 0) ? ir0 : (id == 1) ? ir1 : ir2;
  endfunction

  function automatic logic outv(input int id);
    return (id == 0) ? ov0 : (id == 1) ? ov1 : ov2;
  endfunction

  task automatic drive(input int id, input logic v, input logic [63:0] d,
                       input logic [5:0] a, input logic [2:0] op);
    case (id)
      0: begin v0 = v; d0 = d[31:0]; a0 = a[4:0]; op0 = op; end
      1: begin v1 = v; d1 = d[7:0];  a1 = a[2:0]; op1 = op; end
      default: begin v2 = v; d2 = d; a2 = a; op2 = op; end
    endcase
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int id, input logic [63:0] d, input logic [5:0] a,
                      input logic [2:0] op, input exp_t e);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    drive(id, 1'b1, d, a, op);
    while (!acc) begin
      #2;
      acc = rdy(id);
      @(negedge clk);
      n++;
      if (!acc && n > 100) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout dut%0d: got no in_ready, expected accept", id);
        drive(id, 1'b0, '0, '0, '0);
        return;
      end
    end
    q[id].push_back(e);
    drive(id, 1'b0, '0, '0, '0);
  endtask

  task automatic send_rand(input int id);
    logic [63:0] d;
    int          a;
    logic [2:0]  op;
    d  = {$urandom, $urandom};
    a  = $urandom_range(0, wid(id) - 1);
    op = 3'($urandom_range(0, 7));
    send(id, d, 6'(a), op, model(wid(id), d, a, op));
  endtask

  // Sends one beat into an empty pipe and counts edges until out_valid.
  task automatic lat_check(input int id, input logic [63:0] d, input int a,
                           input logic [2:0] op, input exp_t e, input int exp_lat,
                           input string name);
    int n;
    send(id, d, 6'(a), op, e);
    n = 1;
    #2;
    while (!outv(id) && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(name, 64'(n), 64'(exp_lat));
    @(negedge clk);
  endtask

  task automatic drain(input int id, input string name);
    int n;
    n = 0;
    while (q[id].size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(q[id].size()), 64'd0);
  endtask

  // Output-side checks: hold while stalled, in_ready low while stalled,
  // and in-order comparison of every transferred result.
  task automatic mon(input int id, input logic v, input logic r, input logic ir,
                     input logic [63:0] d, input logic c, input logic z);
    exp_t e;
    if (stall_prev[id]) begin
      chk($sformatf("hold_valid%0d", id), 64'(v), 64'd1);
      chk($sformatf("hold_data%0d", id), d, prev_d[id]);
      chk($sformatf("hold_carry%0d", id), 64'(c), 64'(prev_c[id]));
      chk($sformatf("hold_zero%0d", id), 64'(z), 64'(prev_z[id]));
    end
    if (v && !r) chk($sformatf("in_ready_stall%0d", id), 64'(ir), 64'd0);
    if (v && r) begin
      if (q[id].size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out%0d: got 0x%0h expected no result", id, d);
      end else begin
        e = q[id].pop_front();
        n_pop[id]++;
        chk($sformatf("data%0d", id), d, e.d);
        chk($sformatf("carry%0d", id), 64'(c), 64'(e.c));
        chk($sformatf("zero%0d", id), 64'(z), 64'(e.z));
      end
    end
    stall_prev[id] = v && !r;
    prev_d[id] = d;
    prev_c[id] = c;
    prev_z[id] = z;
  endtask

  always begin
    @(negedge clk);
    #2;
    if (rst_n) mon(0, ov0, or0, ir0, 64'(od0), c0, z0);
    else stall_prev[0] = 1'b0;
  end
  always begin
    @(negedge clk);
    #2;
    if (rst_n) mon(1, ov1, or1, ir1, 64'(od1), c1, z1);
    else stall_prev[1] = 1'b0;
  end
  always begin
    @(negedge clk);
    #2;
    if (rst_n) mon(2, ov2, or2, ir2, od2, c2, z2);
    else stall_prev[2] = 1'b0;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    int   nv;
    exp_t e;

    tbl[0]  = '{3'd0, 64'h0000_0001, 31, 64'h8000_0000, 1'b0, 1'b0};
    tbl[1]  = '{3'd1, 64'h0000_0003,  1, 64'h0000_0001, 1'b1, 1'b0};
    tbl[2]  = '{3'd0, 64'h8000_0000,  1, 64'h0000_0000, 1'b1, 1'b1};
    tbl[3]  = '{3'd2, 64'h8000_0000,  4, 64'hF800_0000, 1'b0, 1'b0};
    tbl[4]  = '{3'd2, 64'h7FFF_FFFF, 31, 64'h0000_0000, 1'b1, 1'b1};
    tbl[5]  = '{3'd3, 64'h0000_0001,  1, 64'h8000_0000, 1'b1, 1'b0};
    tbl[6]  = '{3'd4, 64'h8000_0001,  4, 64'h0000_0018, 1'b0, 1'b0};
    tbl[7]  = '{3'd3, 64'hDEAD_BEEF,  0, 64'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[8]  = '{3'd6, 64'h1234_5678,  5, 64'h1234_5678, 1'b0, 1'b0};
    tbl[9]  = '{3'd1, 64'hF000_0000, 31, 64'h0000_0001, 1'b1, 1'b0};
    tbl[10] = '{3'd4, 64'h0000_0001, 31, 64'h8000_0000, 1'b0, 1'b0};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, '0, '0, '0);
    or0 = 1'b1;
    or1 = 1'b1;
    or2 = 1'b1;

    #12;
    chk("rst_valid", 64'(ov0), 64'd0);
    chk("rst_data", 64'(od0), 64'd0);
    chk("rst_carry", 64'(c0), 64'd0);
    chk("rst_zero", 64'(z0), 64'd0);
    chk("rst_data64", od2, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_idle", 64'(ir0), 64'd1);

    // Latency on the first directed vector
    lat_check(0, tbl[0].d, tbl[0].amt, tbl[0].op, '{tbl[0].ed, tbl[0].ec, tbl[0].ez},
              2, "latency_w32");
    drain(0, "drain_lat");

    // Directed table, back to back
    base = n_pop[0];
    for (int i = 0; i < 11; i++) begin
      e = '{tbl[i].ed, tbl[i].ec, tbl[i].ez};
      send(0, tbl[i].d, 6'(tbl[i].amt), tbl[i].op, e);
    end
    drain(0, "drain_table");
    chk("table_count", 64'(n_pop[0] - base), 64'd11);

    // Stream of 16 with a 5-cycle output stall in the middle
    base = n_pop[0];
    fork
      begin
        repeat (16) send_rand(0);
      end
      begin
        repeat (6) @(negedge clk);
        or0 = 1'b0;
        repeat (5) @(negedge clk);
        or0 = 1'b1;
      end
    join
    drain(0, "drain_stream");
    chk("stream_count", 64'(n_pop[0] - base), 64'd16);

    // Reset with two beats in flight
    send_rand(0);
    send_rand(0);
    @(negedge clk);
    #1;
    chk("pre_reset_valid", 64'(ov0), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("reset_valid", 64'(ov0), 64'd0);
    chk("reset_data", 64'(od0), 64'd0);
    chk("reset_carry", 64'(c0), 64'd0);
    q[0].delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (5) begin
      #2;
      if (ov0) nv++;
      @(negedge clk);
    end
    chk("no_stale_result", 64'(nv), 64'd0);
    lat_check(0, 64'h0000_00F0, 4, 3'd1, model(32, 64'h0000_00F0, 4, 3'd1), 2,
              "latency_after_reset");
    drain(0, "drain_reset");

    // Parameter sweeps
    lat_check(1, 64'h81, 3, 3'd3, model(8, 64'h81, 3, 3'd3), 1, "latency_w8");
    lat_check(2, 64'hF000_0000_0000_0001, 63, 3'd2,
              model(64, 64'hF000_0000_0000_0001, 63, 3'd2), 6, "latency_w64");
    drain(1, "drain_lat8");
    drain(2, "drain_lat64");
    sweep_on = 1'b1;
    fork
      begin
        while (sweep_on) begin
          @(negedge clk);
          or1 = 1'($urandom_range(0, 1));
          or2 = 1'($urandom_range(0, 1));
        end
      end
    join_none
    base = n_pop[1];
    nv   = n_pop[2];
    fork
      begin
        repeat (60) begin
          send_rand(1);
          if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
      end
      begin
        repeat (60) begin
          send_rand(2);
          if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
      end
    join
    sweep_on = 1'b0;
    @(negedge clk);
    or1 = 1'b1;
    or2 = 1'b1;
    drain(1, "drain_sweep8");
    drain(2, "drain_sweep64");
    chk("sweep8_count", 64'(n_pop[1] - base), 64'd60);
    chk("sweep64_count", 64'(n_pop[2] - nv), 64'd60);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
Parametrised, pipelined successor to the 32-bit combinational barrel shifter. Performs logical/arithmetic shifts and left/right rotates on WIDTH-bit operands. The log2(WIDTH) mux levels are split across PIPE_STAGES register stages, with a valid/ready handshake on both sides. Also produces carry-out and zero flags, and sits between the operand-select stage and the ALU result mux in the execute path.

Parameters:
WIDTH, 32, operand width; power of two, 8..64
PIPE_STAGES, 2, register stages = latency in cycles; 1..log2(WIDTH)
AMT_W, $clog2(WIDTH), shift amount width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block accepts a beat this cycle
in_data  input  WIDTH  operand
in_amt  input  AMT_W  shift/rotate amount, 0..WIDTH-1
in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, 101-111 reserved
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  result
out_carry  output  1  last bit shifted/rotated out
out_zero  output  1  out_data == 0

Behaviour:
- Reset (rst_n low, async): all stage valid bits clear; out_valid=0, out_data=0, out_carry=0, out_zero=0. in_ready=1 while rst_n is high and the pipe is empty. Deassertion is synchronous to clk via the existing reset synchroniser upstream.
- Reset mid-operation discards all in-flight beats. No result emerges after reset.
- Handshake: a beat transfers on in_valid && in_ready. A result transfers on out_valid && out_ready. in_data, in_amt and in_op are sampled only on transfer.
- Global advance: adv = out_ready || !out_valid; in_ready = adv. When adv=1, every stage register (data, partial result, op, remaining amount bits, valid) loads from its predecessor. When adv=0, all stages hold.
- Bubbles are not compressed. Fixed latency: a beat accepted at cycle N presents on out_data in cycle N+PIPE_STAGES if no stall occurs. Each stall cycle adds exactly one cycle.
- While stalled, out_data, out_carry, out_zero and out_valid stay stable until accepted (AXI-style).
- Full throughput: one beat per cycle when out_ready is held high.
- Stage split: mux levels k=0..log2(WIDTH)-1 (shift by 2^k) are assigned to stages in order. Stage s handles ceil(log2(WIDTH)/PIPE_STAGES) levels; the last stage takes the remainder.
- Arithmetic:
  - SLL fills zeros.
  - SRL fills zeros.
  - SRA fills with in_data[WIDTH-1].
  - ROR/ROL are true rotates modulo WIDTH.
  - Amount 0 returns in_data unchanged for every op, including rotates. The rotate-by-zero result is well-defined.
- out_carry:
  - SLL: in_data[WIDTH-amt].
  - SRL/SRA: in_data[amt-1].
  - ROR: out_data[WIDTH-1].
  - ROL: out_data[0].
  - amt==0: 0 for every op.
  - Carry is tracked through the stages, not recomputed from in_data at the output.
- out_zero is registered with out_data; it is not derived combinationally from the output.
- Reserved ops (101-111): out_data=in_data, out_carry=0, normal latency and handshake. This is not an error.
- Simultaneous input transfer and output transfer in the same cycle is legal and required for full throughput.

Test Plan:
1. WIDTH=32, PIPE_STAGES=2, out_ready=1. Inputs:
   - SLL 0x0000_0001 amt 31 -> 0x8000_0000, carry 0, zero 0, valid exactly 2 cycles after accept.
   - SRL 0x0000_0003 amt 1 -> 0x0000_0001, carry 1.
   - SLL 0x8000_0000 amt 1 -> 0x0000_0000, carry 1, zero 1.
2. SRA 0x8000_0000 amt 4 -> 0xF800_0000, carry 0. SRA 0x7FFF_FFFF amt 31 -> 0x0000_0000, carry 1, zero 1.
3. Rotates:
   - ROR 0x0000_0001 amt 1 -> 0x8000_0000, carry 1.
   - ROL 0x8000_0001 amt 4 -> 0x0000_0018, carry 0.
   - ROR 0xDEAD_BEEF amt 0 -> 0xDEAD_BEEF, carry 0.
   - op 110 on 0x1234_5678 -> 0x1234_5678.
4. Back-to-back stream: 16 random beats, then out_ready low for 5 cycles mid-stream.
   - in_ready goes low the cycle out_valid && !out_ready.
   - Outputs hold stable while stalled.
   - All 16 results arrive in order and match the reference model; none dropped or duplicated.
5. Accept 2 beats, assert rst_n=0 asynchronously between clock edges. out_valid drops immediately and out_data=0. After release no stale result appears, and the next beat returns with 2-cycle latency.
6. Parameter sweep against the reference model, random ops and amounts, with out_ready randomised:
   - WIDTH=8, PIPE_STAGES=1: latency 1.
   - WIDTH=64, PIPE_STAGES=6: latency 6.
